systolic_ctrl: RTL
==================

Name: systolic_ctrl

Overview:
- Sequencer for the 3x3 weight-stationary systolic array of `block` PEs.
- Accepts 9 weights serially, then latches them into the array with a single `weight_en` pulse.
- Streams 3-element activation vectors into the three west inputs with diagonal skew and holds `compute` high.
- De-skews the bottom-row south outputs and emits one aligned 3-element result vector per accepted activation vector.

Parameters:
- DW, 16, data width of every weight, activation and result element.
- ARR_LAT, 3, cycles from driving west row 0 to the column-0 result appearing on `south_in`; column c result arrives ARR_LAT+c cycles after its vector entered row 0.
- CNT_W, 8, width of the vector counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle job request; sampled only in IDLE
- vec_count  in  CNT_W  number of activation vectors in the job; latched on accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on job completion
- wt_valid  in  1  weight word valid
- wt_data  in  DW  weight word, row-major order w0..w8
- wt_ready  out  1  high only in LOAD_W
- weight_bus  out  9*DW  weights to PEs; element k at bits [k*DW +: DW]
- weight_en  out  1  weight latch strobe to all PEs
- act_valid  in  1  activation vector valid
- act_data  in  3*DW  activation vector; element r drives array row r
- act_ready  out  1  high in STREAM while vectors remain
- west_out  out  3*DW  skewed west inputs for rows 0, 1, 2
- compute  out  1  PE compute enable
- south_in  in  3*DW  bottom-row south outputs, columns 0..2
- res_valid  out  1  result vector valid; no backpressure
- res_data  out  3*DW  de-skewed result vector

Behaviour:
- Reset (rst=0, any state, including mid-job): state IDLE; all counters, skew registers, de-skew registers and token pipe cleared. All outputs are 0, including weight_bus.
- IDLE:
  - start=1 latches vec_count, clears the weight index, goes to LOAD_W.
  - start in any other state is ignored.
- LOAD_W:
  - wt_ready=1. Each wt_valid&wt_ready writes wt_data into weight_bus slot idx, then idx++.
  - When the 9th word is accepted, go to LATCH_W.
  - wt_valid low stalls indefinitely.
- LATCH_W:
  - One cycle; weight_en=1, compute=0.
  - Next state is STREAM, or DRAIN if the latched vec_count==0.
- STREAM:
  - compute=1; act_ready=1 while remaining>0.
  - Handshake: remaining decrements; token=1 enters the token pipe; act_data enters the skew stage.
  - Cycle with no handshake: a zero vector with token=0 enters instead.
  - When remaining reaches 0, go to DRAIN.
- Skew:
  - Row r is delayed r cycles before driving west_out.
  - A vector accepted in cycle T drives row 0 at T+1, row 1 at T+2, row 2 at T+3.
- DRAIN:
  - compute=1, act_ready=0; zero vectors with token=0 keep entering.
  - When the token pipe holds no 1s, go to DONE.
- DONE: one cycle; done=1, compute=0; go to IDLE.
- De-skew:
  - south_in column c is delayed (2-c) cycles, then all three columns are registered into res_data.
  - res_valid is the token-pipe output, aligned with res_data.
  - Handshake in cycle T gives res_valid at T+ARR_LAT+4 (7 at defaults); the token pipe is ARR_LAT+4 deep.
- Ordering: results emerge in acceptance order; bubbles never produce res_valid.
- res_data holds its last value when res_valid=0.
- Arithmetic: the controller does no arithmetic on data; widths pass through unchanged.
- weight_bus holds its value after LATCH_W until the next job's LOAD_W overwrites it.

Decomposition:
- Shared package `systolic_pkg`:
  - state enum IDLE/LOAD_W/LATCH_W/STREAM/DRAIN/DONE
  - constants ARRAY_N=3 and NUM_W=9
  - DW default
- One sub-module `skew_line` (parameterized depth and width delay chain with async active-low clear). Used for both the row skew (depth r) and the column de-skew (depth 2-c).

Test Plan:
- Reset mid-STREAM (rst low for 1 cycle at cycle 5 of the job) -> next edge shows busy=0, compute=0, res_valid=0, weight_bus=0; a subsequent start runs normally.
- Weights 1..9 with wt_valid gaps every other cycle -> wt_ready only in LOAD_W; single weight_en pulse with weight_bus slot k == k+1.
- vec_count=2, act_data {3,2,1} then {6,5,4} back-to-back, with a stub array model (ARR_LAT=3) -> west_out row0=1 at T+1, row1=2 at T+2, row2=3 at T+3; res_valid high at T+7 and T+8 only; done one cycle after the token pipe empties.
- vec_count=3 with act_valid low for 2 cycles between vectors -> exactly 3 res_valid pulses, in order, separated by the 2-cycle gap; no spurious valid.
- vec_count=0 -> LOAD_W, LATCH_W, DRAIN, DONE; act_ready never high, zero res_valid, done pulses once.
- start asserted while busy -> ignored; vec_count change mid-job has no effect on the result count.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared constants and state type for the 3x3 systolic array sequencer.
// Imported by the interface and by the controller.
package systolic_pkg;

    localparam int ARRAY_N = 3;
    localparam int NUM_W   = ARRAY_N * ARRAY_N;
    localparam int DW_DEF  = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        LATCH_W = 3'd2,
        STREAM  = 3'd3,
        DRAIN   = 3'd4,
        DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/systolic_ctrl_if.sv
// Job, weight, activation and array-side signals of the sequencer.
// master = environment side, slave = the controller.
interface systolic_ctrl_if
    import systolic_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int CNT_W = 8
);

    logic                     start;
    logic [CNT_W-1:0]         vec_count;
    logic                     busy;
    logic                     done;
    logic                     wt_valid;
    logic [DW-1:0]            wt_data;
    logic                     wt_ready;
    logic [NUM_W*DW-1:0]      weight_bus;
    logic                     weight_en;
    logic                     act_valid;
    logic [ARRAY_N*DW-1:0]    act_data;
    logic                     act_ready;
    logic [ARRAY_N*DW-1:0]    west_out;
    logic                     compute;
    logic [ARRAY_N*DW-1:0]    south_in;
    logic                     res_valid;
    logic [ARRAY_N*DW-1:0]    res_data;

    modport master (
        output start, vec_count, wt_valid, wt_data,
        output act_valid, act_data, south_in,
        input  busy, done, wt_ready, weight_bus, weight_en,
        input  act_ready, west_out, compute, res_valid, res_data
    );

    modport slave (
        input  start, vec_count, wt_valid, wt_data,
        input  act_valid, act_data, south_in,
        output busy, done, wt_ready, weight_bus, weight_en,
        output act_ready, west_out, compute, res_valid, res_data
    );

endinterface

// File: rtl/skew_line.sv
// Fixed-depth delay line with asynchronous active-low clear.
// Used for the row skew and the column de-skew.
module skew_line #(
    parameter int DEPTH = 1,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] d_o
);

    logic [DEPTH-1:0][W-1:0] pipe_q;

    // Shift one stage per cycle; stage 0 takes the input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign d_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for a 3x3 weight-stationary array: loads weights, streams
// skewed activations and re-aligns the bottom-row results.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int ARR_LAT = 3,
    parameter int CNT_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    systolic_ctrl_if.slave bus
);

    localparam int TOK_N = ARR_LAT + 4;
    localparam int WI_W  = $clog2(NUM_W);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_LOAD   = LOAD_W;
    localparam logic [2:0] S_LATCH  = LATCH_W;
    localparam logic [2:0] S_STREAM = STREAM;
    localparam logic [2:0] S_DRAIN  = DRAIN;
    localparam logic [2:0] S_DONE   = DONE;

    localparam logic [WI_W-1:0]  LAST_W = WI_W'(NUM_W - 1);
    localparam logic [WI_W-1:0]  ONE_W  = WI_W'(1);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    logic [2:0]                 state_q, state_d;
    logic [WI_W-1:0]            widx_q, widx_d;
    logic [CNT_W-1:0]           rem_q, rem_d;
    logic [NUM_W-1:0][DW-1:0]   wts_q, wts_d;
    logic [ARRAY_N-1:0][DW-1:0] in_q, in_d;
    logic [TOK_N-1:0]           tok_q, tok_d;
    logic [ARRAY_N-1:0][DW-1:0] res_q, res_d;
    logic [ARRAY_N-1:0][DW-1:0] west;
    logic [ARRAY_N-1:0][DW-1:0] south;
    logic [ARRAY_N-1:0][DW-1:0] dsk;
    logic                       wt_hs;
    logic                       act_hs;

    assign wt_hs  = bus.wt_valid & bus.wt_ready;
    assign act_hs = bus.act_valid & bus.act_ready;
    assign south  = bus.south_in;

    // Job sequencing, weight capture and remaining-vector count.
    always_comb begin
        state_d = state_q;
        widx_d  = widx_q;
        rem_d   = rem_q;
        wts_d   = wts_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    rem_d   = bus.vec_count;
                    widx_d  = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (wt_hs) begin
                    wts_d[widx_q] = bus.wt_data;
                    widx_d        = widx_q + ONE_W;
                    if (widx_q == LAST_W) begin
                        state_d = S_LATCH;
                    end
                end
            end
            S_LATCH: begin
                state_d = (rem_q == '0) ? S_DRAIN : S_STREAM;
            end
            S_STREAM: begin
                if (act_hs) begin
                    rem_d = rem_q - ONE_C;
                    if (rem_q == ONE_C) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (tok_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Skew input stage, token pipe and result capture.
    always_comb begin
        in_d  = act_hs ? bus.act_data : '0;
        tok_d = {tok_q[TOK_N-2:0], act_hs};
        res_d = tok_q[TOK_N-2] ? dsk : res_q;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            widx_q  <= '0;
            rem_q   <= '0;
            wts_q   <= '0;
            in_q    <= '0;
            tok_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            rem_q   <= rem_d;
            wts_q   <= wts_d;
            in_q    <= in_d;
            tok_q   <= tok_d;
            res_q   <= res_d;
        end
    end

    for (genvar r = 0; r < ARRAY_N; r++) begin : g_row
        if (r == 0) begin : g_direct
            assign west[r] = in_q[r];
        end else begin : g_skew
            skew_line #(
                .DEPTH (r),
                .W     (DW)
            ) u_skew (
                .clk   (clk),
                .rst_n (rst),
                .d_i   (in_q[r]),
                .d_o   (west[r])
            );
        end
    end

    for (genvar c = 0; c < ARRAY_N; c++) begin : g_col
        if (c == ARRAY_N - 1) begin : g_direct
            assign dsk[c] = south[c];
        end else begin : g_deskew
            skew_line #(
                .DEPTH (ARRAY_N - 1 - c),
                .W     (DW)
            ) u_deskew (
                .clk   (clk),
                .rst_n (rst),
                .d_i   (south[c]),
                .d_o   (dsk[c])
            );
        end
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.wt_ready   = (state_q == S_LOAD);
    assign bus.weight_en  = (state_q == S_LATCH);
    assign bus.act_ready  = (state_q == S_STREAM) && (rem_q != '0);
    assign bus.compute    = (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign bus.weight_bus = wts_q;
    assign bus.west_out   = west;
    assign bus.res_valid  = tok_q[TOK_N-1];
    assign bus.res_data   = res_q;

endmodule
